lsu_sequencer: RTL

LSU_SEQUENCER -- requirements
Module: lsu_sequencer

---
 rtl/lsu_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: decodes one memory op, runs a single bus access, returns an extended result or an exception.
// Optional bus watchdog enabled by defining LSU_BUS_TIMEOUT_EN (aborts after TIMEOUT_CYCLES wait cycles).
module lsu_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic        bus_err_i,
  input  logic [31:0] bus_rdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rdata_o,
  output logic        exc_o,
  output logic [31:0] exc_cause_o,
  output logic        stall_o
);

  localparam logic [3:0] OP_NOP = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3,
                         OP_LBU = 4'd4, OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7,
                         OP_SW = 4'd8;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2, CAUSE_LD_MIS = 32'd4, CAUSE_LD_FLT = 32'd5,
                          CAUSE_ST_MIS = 32'd6, CAUSE_ST_FLT = 32'd7;

  if (TIMEOUT_CYCLES < 1) begin : g_chk
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t state, state_nx;

  logic        accept;
  logic        is_load, is_store, bad_op, misal, go_bus;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic        tmo_hit;

  logic [3:0]  op_q;
  logic [1:0]  off_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q, wdata_q, rdata_q, cause_q;
  logic        exc_q;

  assign accept = req_valid_i && (state == IDLE);

  always_comb begin
    is_load  = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LHU);
    is_store = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
    bad_op   = (mem_op_i > OP_SW);
    misal    = 1'b0;
    be_d     = 4'b0000;
    wdata_d  = wdata_i;
    unique case (mem_op_i)
      OP_LB, OP_LBU, OP_SB: be_d = 4'b0001 << addr_i[1:0];
      OP_LH, OP_LHU, OP_SH: begin
        be_d  = 4'b0011 << addr_i[1:0];
        misal = addr_i[0];
      end
      OP_LW, OP_SW: begin
        be_d  = 4'b1111;
        misal = (addr_i[1:0] != 2'b00);
      end
      default: be_d = 4'b0000;
    endcase
    // Stores replicate narrow data so the byte enables pick the right lane.
    if (mem_op_i == OP_SB) wdata_d = {4{wdata_i[7:0]}};
    else if (mem_op_i == OP_SH) wdata_d = {2{wdata_i[15:0]}};
    go_bus = (is_load || is_store) && !misal;
  end

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tmo_cnt <= '0;
    else if (accept) tmo_cnt <= '0;
    else if ((state == BUS) && !bus_ack_i) tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Abort on the cycle whose missing ack would bring the count to the limit.
  assign tmo_hit = (state == BUS) && !bus_ack_i && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = go_bus ? BUS : RESP;
      BUS:  if (bus_ack_i || tmo_hit) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [1:0] off,
                                           input logic [31:0] raw);
    logic [31:0] lane;
    lane = raw >> {off, 3'b000};
    unique case (op)
      OP_LB:   return {{24{lane[7]}}, lane[7:0]};
      OP_LBU:  return {24'd0, lane[7:0]};
      OP_LH:   return {{16{lane[15]}}, lane[15:0]};
      OP_LHU:  return {16'd0, lane[15:0]};
      default: return raw;
    endcase
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q    <= OP_NOP;
      off_q   <= 2'b00;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      exc_q   <= 1'b0;
      cause_q <= '0;
    end else if (accept) begin
      op_q    <= mem_op_i;
      off_q   <= addr_i[1:0];
      we_q    <= is_store;
      be_q    <= go_bus ? be_d : 4'b0000;
      addr_q  <= {addr_i[31:2], 2'b00};
      wdata_q <= is_store ? wdata_d : 32'd0;
      rdata_q <= '0;
      // Requests that never reach the bus resolve their outcome right here.
      if (bad_op) begin
        exc_q   <= 1'b1;
        cause_q <= CAUSE_ILLEGAL;
      end else if ((is_load || is_store) && misal) begin
        exc_q   <= 1'b1;
        cause_q <= is_load ? CAUSE_LD_MIS : CAUSE_ST_MIS;
      end else begin
        exc_q   <= 1'b0;
        cause_q <= '0;
      end
    end else if ((state == BUS) && (bus_ack_i || tmo_hit)) begin
      if (tmo_hit || bus_err_i) begin
        exc_q   <= 1'b1;
        cause_q <= we_q ? CAUSE_ST_FLT : CAUSE_LD_FLT;
        rdata_q <= '0;
      end else begin
        exc_q   <= 1'b0;
        cause_q <= '0;
        rdata_q <= we_q ? 32'd0 : load_ext(op_q, off_q, bus_rdata_i);
      end
    end
  end

  assign req_ready_o = (state == IDLE);
  assign bus_req_o   = (state == BUS);
  assign bus_we_o    = (state == BUS) && we_q;
  assign bus_be_o    = (state == BUS) ? be_q : 4'b0000;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign rsp_valid_o = (state == RESP);
  assign rdata_o     = rdata_q;
  assign exc_o       = exc_q;
  assign exc_cause_o = cause_q;
  assign stall_o     = !rst_i && ((state == BUS) || ((state == IDLE) && req_valid_i));

endmodule
